// File: rtl/add128_loader.sv
// Serial-load 128-bit adder/subtractor: operand A then operand B arrive as W-bit
// beats (LSB beat first), one combinational add in EXEC, result held in DONE until taken.
module add128_loader #(
    parameter int unsigned W = 32  // must divide 128
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic           in_op,
    input  logic           in_cin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_sum,
    output logic           out_cout,
    output logic           out_ovf
);

    localparam int unsigned N  = 128 / W;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] LOAD_A = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]    state, state_nxt;
    logic          in_ready_nxt, out_valid_nxt;
    logic [CW-1:0] cnt;
    logic [127:0]  a_q, b_q;
    logic          op_q, cin_q;

    logic          xfer;
    logic          last_beat;
    logic [127:0]  b_eff;
    logic          c_eff;
    logic [128:0]  sum_ext;
    logic          ovf_c;

    assign xfer      = in_valid & in_ready;
    assign last_beat = (cnt == CW'(N - 1));

    // State register; handshake flags are registered alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // Next-state and next handshake flags
    always_comb begin
        state_nxt     = state;
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
        case (state)
            LOAD_A:  if (xfer && last_beat) state_nxt = LOAD_B;
            LOAD_B:  if (xfer && last_beat) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = LOAD_A;
            default: state_nxt = LOAD_A;
        endcase
        in_ready_nxt  = (state_nxt == LOAD_A) || (state_nxt == LOAD_B);
        out_valid_nxt = (state_nxt == DONE);
    end

    // Beat counter wraps after the last beat of each operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (xfer) begin
            cnt <= last_beat ? '0 : cnt + CW'(1);
        end
    end

    // Operand capture; op/cin come only with beat 0 of A
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= 1'b0;
            cin_q <= 1'b0;
        end else if (xfer) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (cnt == CW'(k)) begin
                    if (state == LOAD_A) a_q[k*W +: W] <= in_data;
                    if (state == LOAD_B) b_q[k*W +: W] <= in_data;
                end
            end
            if (state == LOAD_A && cnt == '0) begin
                op_q  <= in_op;
                cin_q <= in_cin;
            end
        end
    end

    // Subtract is A + ~B + 1
    always_comb begin
        b_eff   = op_q ? ~b_q : b_q;
        c_eff   = op_q | cin_q;
        sum_ext = {1'b0, a_q} + {1'b0, b_eff} + 129'(c_eff);
        ovf_c   = (a_q[127] == b_eff[127]) && (sum_ext[127] != a_q[127]);
    end

    // Result registers update only on the EXEC cycle and otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (state == EXEC) begin
            out_sum  <= sum_ext[127:0];
            out_cout <= sum_ext[128];
            out_ovf  <= ovf_c;
        end
    end

endmodule
